terminal_writer: RTL and testbench
==================================

TERMINAL_WRITER -- requirements
Module: terminal_writer

Interface
REQ-001 The block SHALL have parameter BLANK_CHAR, default 8'h20, which is the byte written by erase operations.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
- pclk  input  1  clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high reset.
- in_data  input  8  incoming character/command byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the block can accept a byte this cycle.
- buf_addr  output  10  character buffer write address, {row[3:0], col[5:0]}.
- buf_data  output  8  character buffer write data.
- buf_we  output  1  character buffer write strobe, one cycle per write.
- new_cursor_x  output  6  cursor column to load.
- new_cursor_y  output  4  cursor row to load.
- write_cursor_pos  output  1  one-cycle strobe that loads new_cursor_x/y.
- scroll_req  output  1  one-cycle strobe requesting a one-line scroll.

Function
REQ-003 A byte SHALL be accepted on a cycle where in_valid and in_ready are both 1; in_data SHALL be ignored on any other cycle.
REQ-004 The block SHALL keep an internal cursor (x 0..63, y 0..15) and SHALL drive new_cursor_x/y from it at all times.
REQ-005 Every accepted byte that changes the cursor SHALL pulse write_cursor_pos in the following cycle, with new_cursor_x/y already holding the updated values; accepted bytes that do not change the cursor SHALL NOT pulse it.
REQ-006 All effects (buf_we, scroll_req, write_cursor_pos) SHALL appear exactly one cycle after acceptance; outputs are registered.
REQ-007 FSM states SHALL be IDLE, ESC, ESC_Y_ROW, ESC_Y_COL, CLEAR_EOL.
REQ-008 In IDLE, a printable byte (0x20-0x7E) SHALL be written to buf_addr={y,x}, and x SHALL then be incremented, saturating at 63 (no autowrap).
REQ-009 In IDLE, the control bytes SHALL behave as follows:
- CR (0x0D): x=0.
- LF (0x0A): y+1; at y=15, y is unchanged and scroll_req pulses.
- BS (0x08): x-1, saturating at 0.
- TAB (0x09): x moves to the next multiple of 8, saturating at 63.
- ESC (0x1B): go to state ESC.
- All other bytes <0x20, and 0x7F: ignored, no outputs.
REQ-010 In ESC, the next accepted byte SHALL act as follows:
- 'A': y-1, saturating at 0.
- 'B': y+1, saturating at 15, no scroll.
- 'C': x+1, saturating at 63.
- 'D': x-1, saturating at 0.
- 'H': x=y=0.
- 'K': go to CLEAR_EOL.
- 'Y': go to ESC_Y_ROW.
- Any other byte: ignored.
- Every case except 'K' and 'Y' returns to IDLE.
REQ-011 In ESC_Y_ROW, the accepted byte minus 32 SHALL be latched as the pending row, and the FSM SHALL go to ESC_Y_COL.
REQ-012 In ESC_Y_COL, the accepted byte minus 32 SHALL be the pending column; y SHALL take the pending row only if it is 0..15, x SHALL take the pending column only if it is 0..63, and the FSM SHALL return to IDLE.
REQ-013 In ESC_Y_ROW and ESC_Y_COL, a byte <0x20, including ESC, SHALL count as out-of-range, leaving that coordinate unchanged.
REQ-014 The write_cursor_pos strobe after ESC Y SHALL fire only if x or y actually changed.
REQ-015 In CLEAR_EOL, in_ready SHALL be 0, and the block SHALL write BLANK_CHAR to columns x..63 of row y, one per cycle in ascending order.
REQ-016 CLEAR_EOL SHALL last exactly 64-x cycles, SHALL NOT change the cursor, and SHALL return to IDLE after the column-63 write, with in_ready=1 on the next cycle.
REQ-017 in_ready SHALL be 1 in every state except CLEAR_EOL.
REQ-018 When buf_we is 0, buf_addr and buf_data SHALL hold their last values.

Reset
REQ-019 On clr=1 at a clock edge, all of the following SHALL hold in the next cycle:
- FSM = IDLE, cursor = (0,0), new_cursor_x=0, new_cursor_y=0.
- buf_we=0, write_cursor_pos=0, scroll_req=0, buf_addr=0, buf_data=0, in_ready=1.
REQ-020 Reset SHALL abort any in-progress CLEAR_EOL or escape sequence immediately, with no further buffer writes.
REQ-021 A byte presented in the reset cycle SHALL NOT be accepted.

Verification
REQ-022 Reset, then send 'H','i' -> buf_we at addr 0 data 0x48, then at addr 1 data 0x69; cursor ends at x=2, with two write_cursor_pos pulses.
REQ-023 At x=63, send 'Z' -> buf_we at col 63; x stays 63; no write_cursor_pos pulse.
REQ-024 At y=15, send LF -> one scroll_req pulse; y=15; no write_cursor_pos pulse.
REQ-025 Send ESC,'Y',0x25,0x2A -> y=5, x=10, one write_cursor_pos pulse; then ESC,'Y',0x40,0x21 -> y stays 5 (row 32 out of range), x=1.
REQ-026 At x=60, y=3, send ESC,'K' -> in_ready=0 for 4 cycles with writes of 0x20 to addrs {3,60}..{3,63}, cursor unchanged; repeat the sequence with clr asserted after the second write -> no further writes, state IDLE, cursor (0,0).
REQ-027 Send ESC,'Q' then 'a' -> 'Q' is ignored; 'a' is written at the cursor.

Source files
------------

// File: rtl/terminal_writer.sv
// Terminal character writer: turns a byte stream into character buffer writes
// and cursor updates. It handles the CR/LF/BS/TAB controls and the VT52-style
// ESC A/B/C/D/H/K/Y sequences.
module terminal_writer #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       pclk,
  input  logic       clr,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] buf_addr,
  output logic [7:0] buf_data,
  output logic       buf_we,
  output logic [5:0] new_cursor_x,
  output logic [3:0] new_cursor_y,
  output logic       write_cursor_pos,
  output logic       scroll_req
);

  localparam int unsigned XW = 6;
  localparam int unsigned YW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = XW + YW;

  localparam logic [XW-1:0] X_MAX = XW'(63);
  localparam logic [YW-1:0] Y_MAX = YW'(15);

  localparam logic [DW-1:0] C_BS  = 8'h08;
  localparam logic [DW-1:0] C_TAB = 8'h09;
  localparam logic [DW-1:0] C_LF  = 8'h0A;
  localparam logic [DW-1:0] C_CR  = 8'h0D;
  localparam logic [DW-1:0] C_ESC = 8'h1B;

  typedef enum logic [2:0] {
    IDLE,
    ESC,
    ESC_Y_ROW,
    ESC_Y_COL,
    CLEAR_EOL
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [YW-1:0] row_q, row_d;
  logic          row_ok_q, row_ok_d;
  logic [XW-1:0] col_q, col_d;
  logic          ready_q, ready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          wcp_q, wcp_d;
  logic          scroll_q, scroll_d;

  logic          accept;
  logic [XW:0]   tab_sum;
  logic [XW-1:0] tab_x;

  assign accept  = in_valid && ready_q;
  // Next multiple of 8; bit 6 set means we ran past the last column.
  assign tab_sum = ({1'b0, x_q} + (XW+1)'(8)) & (XW+1)'(8'h78);
  assign tab_x   = tab_sum[XW] ? X_MAX : tab_sum[XW-1:0];

  // Next-state, cursor and write decode for one accepted byte or one erase step.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    row_d    = row_q;
    row_ok_d = row_ok_q;
    col_d    = col_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    scroll_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            we_d   = 1'b1;
            addr_d = {y_q, x_q};
            data_d = in_data;
            if (x_q != X_MAX) x_d = x_q + XW'(1);
          end else begin
            case (in_data)
              C_CR:  x_d = '0;
              C_LF: begin
                if (y_q == Y_MAX) scroll_d = 1'b1;
                else              y_d = y_q + YW'(1);
              end
              C_BS:  if (x_q != '0) x_d = x_q - XW'(1);
              C_TAB: x_d = tab_x;
              C_ESC: state_d = ESC;
              default: ;
            endcase
          end
        end
      end

      ESC: begin
        if (accept) begin
          state_d = IDLE;
          case (in_data)
            8'h41: if (y_q != '0)    y_d = y_q - YW'(1);
            8'h42: if (y_q != Y_MAX) y_d = y_q + YW'(1);
            8'h43: if (x_q != X_MAX) x_d = x_q + XW'(1);
            8'h44: if (x_q != '0)    x_d = x_q - XW'(1);
            8'h48: begin
              x_d = '0;
              y_d = '0;
            end
            8'h4B: begin
              state_d = CLEAR_EOL;
              col_d   = x_q;
            end
            8'h59: state_d = ESC_Y_ROW;
            default: ;
          endcase
        end
      end

      ESC_Y_ROW: begin
        if (accept) begin
          row_d    = YW'(in_data - 8'h20);
          row_ok_d = (in_data >= 8'h20) && (in_data <= 8'h2F);
          state_d  = ESC_Y_COL;
        end
      end

      ESC_Y_COL: begin
        if (accept) begin
          if (row_ok_q) y_d = row_q;
          if (in_data >= 8'h20 && in_data <= 8'h5F) x_d = XW'(in_data - 8'h20);
          state_d = IDLE;
        end
      end

      CLEAR_EOL: begin
        we_d   = 1'b1;
        addr_d = {y_q, col_q};
        data_d = BLANK_CHAR;
        if (col_q == X_MAX) state_d = IDLE;
        else                col_d   = col_q + XW'(1);
      end

      default: state_d = IDLE;
    endcase
  end

  // Ready and cursor strobe derive from the next state so both are registered.
  always_comb begin
    ready_d = (state_d != CLEAR_EOL);
    wcp_d   = (x_d != x_q) || (y_d != y_q);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (clr) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      row_q    <= '0;
      row_ok_q <= 1'b0;
      col_q    <= '0;
      ready_q  <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      wcp_q    <= 1'b0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      row_q    <= row_d;
      row_ok_q <= row_ok_d;
      col_q    <= col_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      wcp_q    <= wcp_d;
      scroll_q <= scroll_d;
    end
  end

  assign in_ready         = ready_q;
  assign buf_addr         = addr_q;
  assign buf_data         = data_q;
  assign buf_we           = we_q;
  assign new_cursor_x     = x_q;
  assign new_cursor_y     = y_q;
  assign write_cursor_pos = wcp_q;
  assign scroll_req       = scroll_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Scoreboard bench for terminal_writer: the driver queues the hand-computed
// writes and cursor updates, and the monitor matches what the DUT emits.
module tb_terminal_writer;

  logic       pclk = 1'b0;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] buf_addr;
  logic [7:0] buf_data;
  logic       buf_we;
  logic [5:0] new_cursor_x;
  logic [3:0] new_cursor_y;
  logic       write_cursor_pos;
  logic       scroll_req;

  int n_cmp = 0;
  int n_err = 0;
  int exp_scroll = 0;
  int got_scroll = 0;

  logic [17:0] wr_q[$];   // {addr, data}
  logic [9:0]  cur_q[$];  // {x, y}

  always #5 pclk = ~pclk;

  terminal_writer #(.BLANK_CHAR(8'h20)) dut (
    .pclk             (pclk),
    .clr              (clr),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .buf_addr         (buf_addr),
    .buf_data         (buf_data),
    .buf_we           (buf_we),
    .new_cursor_x     (new_cursor_x),
    .new_cursor_y     (new_cursor_y),
    .write_cursor_pos (write_cursor_pos),
    .scroll_req       (scroll_req)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int row, input int col, input logic [7:0] d);
    wr_q.push_back({4'(row), 6'(col), d});
  endtask

  task automatic exp_cur(input int x, input int y);
    cur_q.push_back({6'(x), 4'(y)});
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge pclk); #1;
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got in_ready=%b expected 1", in_ready);
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge pclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  // Monitor: every strobe the DUT raises must match the next queued expectation.
  always @(negedge pclk) begin
    logic [17:0] ew;
    logic [9:0]  ec;
    if (buf_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected none", buf_addr, buf_data);
      end else begin
        ew = wr_q.pop_front();
        check("buf_write", {14'h0, buf_addr, buf_data}, {14'h0, ew});
      end
    end
    if (write_cursor_pos === 1'b1) begin
      if (cur_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_cursor: got x=%0d y=%0d expected none", new_cursor_x, new_cursor_y);
      end else begin
        ec = cur_q.pop_front();
        check("cursor_pulse", {22'h0, new_cursor_x, new_cursor_y}, {22'h0, ec});
      end
    end
    if (scroll_req === 1'b1) got_scroll++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset, with a byte offered during reset that must be dropped.
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h58;
    idle(2);
    clr      = 1'b0;
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_buf_we", 32'(buf_we), 0);
    check("rst_buf_addr", 32'(buf_addr), 0);
    check("rst_buf_data", 32'(buf_data), 0);
    check("rst_cursor", {22'h0, new_cursor_x, new_cursor_y}, 0);
    check("rst_wcp", 32'(write_cursor_pos), 0);
    check("rst_scroll", 32'(scroll_req), 0);
    idle(2);

    // "Hi" at the origin.
    exp_wr(0, 0, 8'h48); exp_cur(1, 0); send(8'h48);
    exp_wr(0, 1, 8'h69); exp_cur(2, 0); send(8'h69);
    check("hi_cursor_x", 32'(new_cursor_x), 2);

    // Right-edge saturation: move to column 63 then print.
    exp_cur(63, 0);
    send(8'h1B); send(8'h59); send(8'h20); send(8'h5F);
    exp_wr(0, 63, 8'h5A); send(8'h5A);
    idle(1);
    check("edge_cursor_x", 32'(new_cursor_x), 63);

    // Bottom row line feed scrolls instead of moving.
    exp_cur(0, 15);
    send(8'h1B); send(8'h59); send(8'h2F); send(8'h20);
    exp_scroll++; send(8'h0A);
    idle(1);
    check("lf_cursor_y", 32'(new_cursor_y), 15);

    // Controls: TAB, print, TAB, BS, CR, BS at 0, ignored bytes.
    exp_cur(8, 15);   send(8'h09);
    exp_wr(15, 8, 8'h61); exp_cur(9, 15); send(8'h61);
    exp_cur(16, 15);  send(8'h09);
    exp_cur(15, 15);  send(8'h08);
    exp_cur(0, 15);   send(8'h0D);
    send(8'h08); send(8'h01); send(8'h7F);

    // ESC cursor movement including saturation.
    exp_cur(0, 14); send(8'h1B); send(8'h41);
    exp_cur(0, 15); send(8'h1B); send(8'h42);
    send(8'h1B); send(8'h42);
    exp_cur(1, 15); send(8'h1B); send(8'h43);
    exp_cur(0, 15); send(8'h1B); send(8'h44);
    send(8'h1B); send(8'h44);
    exp_cur(0, 0);  send(8'h1B); send(8'h48);

    // Direct addressing and out-of-range coordinates.
    exp_cur(10, 5); send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
    idle(1);
    check("escy_xy", {22'h0, new_cursor_x, new_cursor_y}, {22'h0, 6'd10, 4'd5});
    exp_cur(1, 5);  send(8'h1B); send(8'h59); send(8'h40); send(8'h21);
    exp_cur(2, 5);  send(8'h1B); send(8'h59); send(8'h1B); send(8'h22);
    send(8'h1B); send(8'h59); send(8'h25); send(8'h22);
    idle(1);
    check("escy_oor_xy", {22'h0, new_cursor_x, new_cursor_y}, {22'h0, 6'd2, 4'd5});

    // TAB saturation near the right edge.
    exp_cur(56, 5); send(8'h1B); send(8'h59); send(8'h25); send(8'h58);
    exp_cur(63, 5); send(8'h09);
    send(8'h09);

    // Erase to end of line from column 60 of row 3.
    exp_cur(60, 3); send(8'h1B); send(8'h59); send(8'h23); send(8'h5C);
    for (int c = 60; c < 64; c++) exp_wr(3, c, 8'h20);
    send(8'h1B); send(8'h4B);
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 200) begin
      @(posedge pclk); #1;
      cnt++;
    end
    check("eol_busy_cycles", 32'(cnt), 4);
    check("eol_cursor", {22'h0, new_cursor_x, new_cursor_y}, {22'h0, 6'd60, 4'd3});
    idle(1);

    // Erase again, aborted by reset after the second write.
    exp_wr(3, 60, 8'h20); exp_wr(3, 61, 8'h20);
    send(8'h1B); send(8'h4B);
    idle(2);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_buf_we", 32'(buf_we), 0);
    check("abort_cursor", {22'h0, new_cursor_x, new_cursor_y}, 0);
    idle(5);

    // Unknown escape is dropped, following byte prints normally.
    send(8'h1B); send(8'h51);
    exp_wr(0, 0, 8'h61); exp_cur(1, 0); send(8'h61);

    idle(5);
    check("pending_writes", 32'(wr_q.size()), 0);
    check("pending_cursor", 32'(cur_q.size()), 0);
    check("scroll_count", 32'(got_scroll), 32'(exp_scroll));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
